// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and a
// variable-latency 64-bit data memory (slave). The request side is held
// stable until dmem_ack. dmem_ack is a single-cycle completion pulse, and
// dmem_rdata is valid only while dmem_ack is high.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// LEGv8 MEM-stage data-memory access unit.
// Runs one req/ack transaction per load or store on a 64-bit data memory.
// Store data and byte strobes are steered onto the addressed lanes, and load
// data is extracted from its lane and zero- or sign-extended. stall holds the
// upstream pipeline and the MEM/WB capture until the DONE cycle.
// Optional build macro MEM_ALIGN_CHECK_EN: when it is defined, a misaligned
// access faults without touching the bus. When it is not defined, the low
// offset bits are cleared to the natural alignment of the access size.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [1:0]               MemSize,
    input  logic                     MemSigned,
    input  logic [63:0]              ALUResult,
    input  logic [63:0]              WriteData,
    output logic [63:0]              MEMout,
    output logic                     stall,
    output logic                     mem_fault,
    mem_access_unit_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bit            TO_EN   = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    logic [TO_W-1:0] to_cnt;

    // Attributes of the access in flight, captured in IDLE.
    logic [2:0]      off_q;
    logic [1:0]      size_q;
    logic            signed_q;
    logic            write_q;

    // Registered bus drivers.
    logic            req_q;
    logic            we_q;
    logic [63:0]     addr_q;
    logic [63:0]     wdata_q;
    logic [7:0]      wstrb_q;

    logic            op;
    logic            is_write;
    logic [2:0]      eff_off;
    logic            misalign;
    logic [7:0]      strb_next;
    logic [63:0]     wdata_next;
    logic [63:0]     rdata_lane;

    // Clears the offset bits below the natural alignment of the access size.
    function automatic logic [2:0] align_off(input logic [2:0] off, input logic [1:0] size);
        logic [2:0] r;
        case (size)
            2'd0:    r = off;
            2'd1:    r = {off[2:1], 1'b0};
            2'd2:    r = {off[2], 2'b00};
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Returns the byte-enable pattern of an access at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Truncates right-aligned load data to the access size and extends it.
    function automatic logic [63:0] load_extend(input logic [63:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [63:0] r;
        case (size)
            2'd0:    r = {{56{sgn & raw[7]}},  raw[7:0]};
            2'd1:    r = {{48{sgn & raw[15]}}, raw[15:0]};
            2'd2:    r = {{32{sgn & raw[31]}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.dmem_wstrb = wstrb_q;

    // Decode the incoming request and steer store data onto its lanes.
    always_comb begin
        op         = MemRead | MemWrite;
        is_write   = MemWrite;
        eff_off    = align_off(ALUResult[2:0], MemSize);
`ifdef MEM_ALIGN_CHECK_EN
        misalign   = (eff_off != ALUResult[2:0]);
`else
        misalign   = 1'b0;
`endif
        strb_next  = size_mask(MemSize) << eff_off;
        wdata_next = WriteData << {eff_off, 3'b000};
        rdata_lane = bus.dmem_rdata >> {off_q, 3'b000};
    end

    // Pipeline stall: asserted on the issue cycle and while waiting, never during reset.
    always_comb begin
        stall = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE:    stall = op;
                BUSY:    stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    // Access sequencer, with registered bus and result outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            to_cnt    <= '0;
            off_q     <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            write_q   <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            MEMout    <= '0;
            mem_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op && misalign) begin
                        // A misaligned access never reaches the bus and faults directly.
                        mem_fault <= 1'b1;
                        state     <= DONE;
                    end else if (op) begin
                        off_q    <= eff_off;
                        size_q   <= MemSize;
                        signed_q <= MemSigned;
                        write_q  <= is_write;
                        to_cnt   <= '0;
                        req_q    <= 1'b1;
                        we_q     <= is_write;
                        addr_q   <= {ALUResult[63:3], 3'b000};
                        wdata_q  <= is_write ? wdata_next : '0;
                        wstrb_q  <= is_write ? strb_next : '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.dmem_ack) begin
                        // An ack arriving in the expiry cycle takes priority over the timeout.
                        req_q     <= 1'b0;
                        mem_fault <= 1'b0;
                        if (!write_q) begin
                            MEMout <= load_extend(rdata_lane, size_q, signed_q);
                        end
                        state <= DONE;
                    end else if (TO_EN && (to_cnt == TO_LAST)) begin
                        req_q     <= 1'b0;
                        mem_fault <= 1'b1;
                        if (!write_q) begin
                            MEMout <= '0;
                        end
                        state <= DONE;
                    end else if (TO_EN) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    mem_fault <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. A reference model derives the
// expected bus lanes, load results, stall length and fault status directly
// from the access attributes using plain arithmetic. The bench acts as the
// data memory, with a randomised ack latency.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [63:0] ALUResult;
    logic [63:0] WriteData;
    logic [63:0] MEMout;
    logic        stall;
    logic        mem_fault;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] ref_memout;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .TIMEOUT (TO),
        .TO_W    (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemSize   (MemSize),
        .MemSigned (MemSigned),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .MEMout    (MEMout),
        .stall     (stall),
        .mem_fault (mem_fault),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Expected load result: select bytes [eoff, eoff+nb) of the doubleword, then extend.
    function automatic logic [63:0] model_load(input logic [63:0] rdata, input int eoff,
                                               input int nb, input logic sgn);
        logic [63:0] v;
        logic [63:0] keep;
        v = rdata >> (8 * eoff);
        if (nb < 8) begin
            keep = (64'd1 << (8 * nb)) - 64'd1;
            v = v & keep;
            if (sgn && v[8 * nb - 1]) v = v | ~keep;
        end
        return v;
    endfunction

    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic sg, input logic [63:0] addr, input logic [63:0] wd,
                              input logic [63:0] rdata, input int ack_at);
        int   nb, off, eoff, busy, stalls, reqs;
        logic misal, fault_exp;
        nb    = 1 << sz;
        off   = int'(addr[2:0]);
        eoff  = off - (off % nb);
        misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misal = ((off % nb) != 0);
`endif
        if (misal) begin
            busy = 0; fault_exp = 1'b1;
        end else if (ack_at >= 1 && ack_at <= TO) begin
            busy = ack_at; fault_exp = 1'b0;
        end else begin
            busy = TO; fault_exp = 1'b1;
        end

        @(negedge clock);
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
        ALUResult = addr; WriteData = wd;
        #1;
        check_val("issue_stall", stall, 1);
        stalls = 1;
        reqs   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            bus.dmem_ack = 1'b0;
            if (!stall) break;
            stalls++;
            if (bus.dmem_req) reqs++;
            if (k == 1 && busy > 0) begin
                check_val("addr",  bus.dmem_addr, addr & ~64'h7);
                check_val("we",    bus.dmem_we, wr);
                check_val("wstrb", bus.dmem_wstrb,
                          wr ? ((64'd1 << nb) - 64'd1) << eoff : 64'd0);
                if (wr) check_val("wdata", bus.dmem_wdata, wd << (8 * eoff));
            end
            if (k == ack_at) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = rdata;
            end
        end
        if (!misal && !wr) ref_memout = fault_exp ? 64'd0 : model_load(rdata, eoff, nb, sg);

        check_val("done_stall",   stall, 0);
        check_val("stall_cycles", stalls, 1 + busy);
        check_val("req_cycles",   reqs, busy);
        check_val("done_fault",   mem_fault, fault_exp);
        check_val("done_req",     bus.dmem_req, 0);
        check_val("memout",       MEMout, ref_memout);
        MemRead = 1'b0; MemWrite = 1'b0;

        @(negedge clock);
        #1;
        check_val("idle_fault", mem_fault, 0);
        check_val("idle_stall", stall, 0);
    endtask

    task automatic reset_mid_busy(input logic [63:0] addr);
        @(negedge clock);
        MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'd3; MemSigned = 1'b0; ALUResult = addr;
        @(negedge clock);
        @(negedge clock);
        check_val("rst_wait_req", bus.dmem_req, 1);
        reset_n = 1'b0; MemRead = 1'b0;
        #1;
        check_val("rst_stall_low", stall, 0);
        @(negedge clock);
        reset_n = 1'b1;
        ref_memout = 64'd0;
        check_val("rst_req",    bus.dmem_req, 0);
        check_val("rst_memout", MEMout, ref_memout);
        check_val("rst_fault",  mem_fault, 0);
        @(negedge clock);
        @(negedge clock);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = {$urandom, $urandom};
        @(negedge clock);
        bus.dmem_ack = 1'b0;
        check_val("late_ack_memout", MEMout, ref_memout);
        check_val("late_ack_req",    bus.dmem_req, 0);
        check_val("late_ack_stall",  stall, 0);
        check_val("late_ack_fault",  mem_fault, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'd0; MemSigned = 1'b0;
        ALUResult = '0; WriteData = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        ref_memout = '0;
        repeat (2) @(negedge clock);
        #1;
        check_val("reset_memout", MEMout, 0);
        check_val("reset_req",    bus.dmem_req, 0);
        check_val("reset_we",     bus.dmem_we, 0);
        check_val("reset_addr",   bus.dmem_addr, 0);
        check_val("reset_wstrb",  bus.dmem_wstrb, 0);
        check_val("reset_wdata",  bus.dmem_wdata, 0);
        check_val("reset_fault",  mem_fault, 0);
        MemRead = 1'b1;
        #1;
        check_val("reset_stall_forced", stall, 0);
        MemRead = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_val("noop_stall", stall, 0);

        // Directed cases.
        run_access(1, 0, 2'd3, 0, 64'h1000, 64'h0, 64'h1122334455667788, 1);
        run_access(1, 0, 2'd0, 1, 64'h1005, 64'h0, 64'h0000_8000_0000_0000, 1);
        run_access(1, 0, 2'd0, 0, 64'h1005, 64'h0, 64'h0000_8000_0000_0000, 2);
        run_access(0, 1, 2'd2, 0, 64'h2004, 64'hDEADBEEF, 64'h0, 1);
        run_access(1, 0, 2'd1, 1, 64'h2006, 64'h0, 64'h9ABC_0000_0000_0000, 3);
        run_access(1, 0, 2'd3, 0, 64'h3000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_access(1, 0, 2'd2, 1, 64'h3004, 64'h0, 64'h8765_4321_0000_0000, 4);
        run_access(1, 1, 2'd1, 0, 64'h4002, 64'hA5A5, 64'h0, 2);
        run_access(0, 1, 2'd3, 0, 64'h5000, 64'h0123456789ABCDEF, 64'h0, 0);

        // Randomised accesses.
        for (int n = 0; n < 80; n++) begin
            logic [1:0] op;
            op = 2'($urandom_range(1, 3));
            run_access(op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                       int'($urandom_range(0, 6)));
        end

        // Make MEMout non-zero, then reset while waiting for an ack.
        run_access(1, 0, 2'd3, 0, 64'h6000, 64'h0, 64'hCAFEF00D12345678, 1);
        reset_mid_busy(64'h7000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
